// File: rtl/jk_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and toggle-mask helpers for the JK bank controller.
package jk_ctrl_pkg;

  localparam int unsigned MAX_WIDTH = 16;

  localparam logic [2:0] OP_HOLD   = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_CLEAR  = 3'd2;
  localparam logic [2:0] OP_SET    = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_INC    = 3'd5;
  localparam logic [2:0] OP_DEC    = 3'd6;
  localparam logic [2:0] OP_ILL    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  // Bit i toggles on increment when every lower bit is 1.
  function automatic logic [MAX_WIDTH-1:0] f_inc_mask(input logic [MAX_WIDTH-1:0] q);
    logic [MAX_WIDTH-1:0] t;
    t[0] = 1'b1;
    for (int i = 1; i < MAX_WIDTH; i++) t[i] = t[i-1] & q[i-1];
    return t;
  endfunction

  // Bit i toggles on decrement when every lower bit is 0.
  function automatic logic [MAX_WIDTH-1:0] f_dec_mask(input logic [MAX_WIDTH-1:0] q);
    logic [MAX_WIDTH-1:0] t;
    t[0] = 1'b1;
    for (int i = 1; i < MAX_WIDTH; i++) t[i] = t[i-1] & ~q[i-1];
    return t;
  endfunction

endpackage

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH edge-triggered JK flip-flops sharing one enable; async active-low reset to 0.
module jk_ff_bank #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Characteristic equation: Q+ = J&~Q | ~K&Q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= (j & ~r_q) | (~k & r_q);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a JK flip-flop bank: decodes one command into a single-cycle J/K/enable
// pulse, then checks the bank feedback against the expected value and reports done/err.
module jk_bank_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  output logic             jk_en,
  input  logic [WIDTH-1:0] q_in,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] q_exp
);
  import jk_ctrl_pkg::*;

  state_e           r_state, w_state_d;
  logic             r_ready, w_ready_d;
  logic             r_en, w_en_d;
  logic             r_done, w_done_d;
  logic             r_err, w_err_d;
  logic             r_ill, w_ill_d;
  logic [WIDTH-1:0] r_j, w_j_d;
  logic [WIDTH-1:0] r_k, w_k_d;
  logic [WIDTH-1:0] r_q_exp, w_q_exp_d;

  logic [MAX_WIDTH-1:0] w_q16, w_inc16, w_dec16;
  logic [WIDTH-1:0]     w_inc, w_dec;
  logic                 w_accept;

  assign w_q16    = MAX_WIDTH'(q_in);
  assign w_inc16  = f_inc_mask(w_q16);
  assign w_dec16  = f_dec_mask(w_q16);
  assign w_inc    = w_inc16[WIDTH-1:0];
  assign w_dec    = w_dec16[WIDTH-1:0];
  assign w_accept = cmd_valid && r_ready;

  always_comb begin
    w_state_d = r_state;
    w_ready_d = r_ready;
    w_en_d    = 1'b0;
    w_done_d  = 1'b0;
    w_err_d   = 1'b0;
    w_ill_d   = r_ill;
    w_j_d     = '0;
    w_k_d     = '0;
    w_q_exp_d = r_q_exp;
    unique case (r_state)
      ST_IDLE: begin
        w_ready_d = 1'b1;
        if (w_accept) begin
          w_ready_d = 1'b0;
          w_ill_d   = 1'b0;
          w_en_d    = 1'b1;
          w_state_d = ST_APPLY;
          unique case (cmd_op)
            OP_HOLD:   begin w_q_exp_d = q_in; end
            OP_LOAD:   begin w_j_d = cmd_data; w_k_d = ~cmd_data; w_q_exp_d = cmd_data; end
            OP_CLEAR:  begin w_k_d = '1; w_q_exp_d = '0; end
            OP_SET:    begin w_j_d = '1; w_q_exp_d = '1; end
            OP_TOGGLE: begin w_j_d = cmd_data; w_k_d = cmd_data; w_q_exp_d = q_in ^ cmd_data; end
            OP_INC:    begin w_j_d = w_inc; w_k_d = w_inc; w_q_exp_d = q_in + 1'b1; end
            OP_DEC:    begin w_j_d = w_dec; w_k_d = w_dec; w_q_exp_d = q_in - 1'b1; end
            default: begin
              // Illegal opcode skips the bank entirely and is flagged at completion.
              w_en_d    = 1'b0;
              w_ill_d   = 1'b1;
              w_q_exp_d = q_in;
              w_state_d = ST_CHECK;
            end
          endcase
        end
      end
      ST_APPLY: w_state_d = ST_CHECK;
      ST_CHECK: begin
        w_done_d  = 1'b1;
        w_err_d   = r_ill || (q_in != r_q_exp);
        w_ready_d = 1'b1;
        w_state_d = ST_IDLE;
      end
      default: begin
        w_ready_d = 1'b0;
        w_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ill   <= 1'b0;
      r_j     <= '0;
      r_k     <= '0;
      r_q_exp <= '0;
    end else begin
      r_state <= w_state_d;
      r_ready <= w_ready_d;
      r_en    <= w_en_d;
      r_done  <= w_done_d;
      r_err   <= w_err_d;
      r_ill   <= w_ill_d;
      r_j     <= w_j_d;
      r_k     <= w_k_d;
      r_q_exp <= w_q_exp_d;
    end
  end

  assign cmd_ready = r_ready;
  assign jk_en     = r_en;
  assign jk_j      = r_j;
  assign jk_k      = r_k;
  assign done      = r_done;
  assign err       = r_err;
  assign q_exp     = r_q_exp;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed bench: controller plus a JK bank, with an override on the feedback path.
module tb_jk_bank_ctrl;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'd0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [WIDTH-1:0] jk_j, jk_k, q_in, q_bank, q_exp;
  logic             jk_en, done, err;
  logic             force_en = 1'b0;
  logic [WIDTH-1:0] force_val = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign q_in = force_en ? force_val : q_bank;

  jk_bank_ctrl #(.WIDTH(WIDTH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .jk_j      (jk_j),
    .jk_k      (jk_k),
    .jk_en     (jk_en),
    .q_in      (q_in),
    .done      (done),
    .err       (err),
    .q_exp     (q_exp)
  );

  jk_ff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (jk_en),
    .j     (jk_j),
    .k     (jk_k),
    .q     (q_bank)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and follow it to completion; accept lands on the next rising edge.
  task automatic do_cmd(input logic [2:0] op, input logic [3:0] data, input logic [3:0] ej,
                        input logic [3:0] ek, input logic [3:0] eq, input logic eerr);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    check("ready_before", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd3;
    cmd_data  = ~data;
    check("ready_low_1", 32'(cmd_ready), 32'd0);
    if (op == 3'd7) begin
      check("ill_no_en", 32'(jk_en), 32'd0);
      @(posedge clk); #1;
      check("ill_done", 32'(done), 32'd1);
      check("ill_err", 32'(err), 32'd1);
      check("ill_ready", 32'(cmd_ready), 32'd1);
      check("ill_q", 32'(q_bank), 32'(eq));
    end else begin
      check("apply_en", 32'(jk_en), 32'd1);
      check("apply_j", 32'(jk_j), 32'(ej));
      check("apply_k", 32'(jk_k), 32'(ek));
      check("apply_qexp", 32'(q_exp), 32'(eq));
      check("apply_nodone", 32'(done), 32'd0);
      @(posedge clk); #1;
      check("check_en", 32'(jk_en), 32'd0);
      check("check_jk", 32'({jk_j, jk_k}), 32'd0);
      check("check_q", 32'(q_bank), 32'(eq));
      check("check_nodone", 32'(done), 32'd0);
      check("ready_low_2", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
      check("done", 32'(done), 32'd1);
      check("err", 32'(err), 32'(eerr));
      check("done_ready", 32'(cmd_ready), 32'd1);
      check("done_q", 32'(q_bank), 32'(eq));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_outs", 32'({jk_en, done, err, jk_j, jk_k, q_exp}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("rel_ready_pre", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("rel_ready", 32'(cmd_ready), 32'd1);

    do_cmd(3'd1, 4'hA, 4'hA, 4'h5, 4'hA, 1'b0);  // LOAD A
    do_cmd(3'd3, 4'h0, 4'hF, 4'h0, 4'hF, 1'b0);  // SET
    do_cmd(3'd5, 4'h0, 4'hF, 4'hF, 4'h0, 1'b0);  // INC wraps F->0
    do_cmd(3'd6, 4'h0, 4'hF, 4'hF, 4'hF, 1'b0);  // DEC wraps 0->F
    do_cmd(3'd1, 4'h5, 4'h5, 4'hA, 4'h5, 1'b0);  // LOAD 5
    do_cmd(3'd4, 4'h3, 4'h3, 4'h3, 4'h6, 1'b0);  // TOGGLE 3
    do_cmd(3'd0, 4'h9, 4'h0, 4'h0, 4'h6, 1'b0);  // HOLD
    do_cmd(3'd5, 4'h0, 4'h1, 4'h1, 4'h7, 1'b0);  // INC 6->7
    do_cmd(3'd6, 4'h0, 4'h1, 4'h1, 4'h6, 1'b0);  // DEC 7->6
    do_cmd(3'd2, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0);  // CLEAR
    do_cmd(3'd1, 4'h6, 4'h6, 4'h9, 4'h6, 1'b0);  // LOAD 6
    do_cmd(3'd7, 4'h0, 4'h0, 4'h0, 4'h6, 1'b1);  // illegal

    // Corrupt the feedback during CHECK.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 4'h9;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("force_bank_q", 32'(q_bank), 32'h9);
    force_en = 1'b1; force_val = 4'h2;
    @(posedge clk); #1;
    check("force_done", 32'(done), 32'd1);
    check("force_err", 32'(err), 32'd1);
    force_en = 1'b0;

    // Back-to-back: valid held, second accept in the done cycle.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_data = 4'h0;
    @(posedge clk); #1;
    check("b2b_set_en", 32'(jk_en), 32'd1);
    check("b2b_set_jk", 32'({jk_j, jk_k}), 32'hF0);
    check("b2b_rdy_a", 32'(cmd_ready), 32'd0);
    cmd_op = 3'd2;
    @(posedge clk); #1;
    check("b2b_rdy_b", 32'(cmd_ready), 32'd0);
    check("b2b_q_f", 32'(q_bank), 32'hF);
    @(posedge clk); #1;
    check("b2b_done1", 32'({done, err, cmd_ready}), 32'b101);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("b2b_clr_en", 32'(jk_en), 32'd1);
    check("b2b_clr_jk", 32'({jk_j, jk_k}), 32'h0F);
    check("b2b_rdy_c", 32'({cmd_ready, done}), 32'd0);
    @(posedge clk); #1;
    check("b2b_q_0", 32'(q_bank), 32'h0);
    check("b2b_rdy_d", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("b2b_done2", 32'({done, err, cmd_ready}), 32'b101);
    check("b2b_qexp", 32'(q_exp), 32'h0);

    // Reset while in APPLY.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 4'h5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("mid_en", 32'(jk_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", 32'({jk_en, done, err, cmd_ready, jk_j, jk_k, q_exp}), 32'd0);
    check("mid_rst_q", 32'(q_bank), 32'h0);
    @(posedge clk); #1;
    check("mid_rst_nodone", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rel_ready_pre", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("mid_rel_ready", 32'(cmd_ready), 32'd1);
    check("mid_rel_state", 32'({done, jk_en, q_bank}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
